pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//   Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit group-chained CLA.
//   Operand width, lookahead group size and pipeline depth are parameters; adds subtract mode, signed-overflow
//   and zero flags, and a valid/ready handshake. Sits in the datapath between operand registers and the ALU result mux.
// PARAMETERS
//   WIDTH   32  operand/result width in bits
//   GROUP   4   bits per carry-lookahead group (generate/propagate unit)
//   STAGES  2   pipeline stages; each stage resolves WIDTH/STAGES bits; must divide WIDTH, and GROUP must divide WIDTH/STAGES
// PORTS
//   Clk        in   1      clock, rising edge
//   Rs         in   1      asynchronous reset, active-low
//   in_valid   in   1      operand beat present
//   in_ready   out  1      block accepts a beat this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   cIn        in   1      carry-in
//   Sub        in   1      0 = add, 1 = subtract
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts result
//   Sum        out  WIDTH  result
//   cOut       out  1      raw carry-out of MSB
//   Ovf        out  1      signed overflow
//   Zero       out  1      Sum == 0
// BEHAVIOUR
//   Arithmetic: Beff = B ^ {WIDTH{Sub}}; ceff = cIn ^ Sub; {cOut,Sum} = A + Beff + ceff (mod 2^(WIDTH+1)).
//     Sub=1,cIn=0 -> A-B; Sub=1,cIn=1 -> A-B-1. cOut is the unmodified carry (1 = no borrow on subtract).
//     Ovf = (A[MSB] == Beff[MSB]) && (Sum[MSB] != A[MSB]). Zero = ~|Sum.
//   Within a slice: per-GROUP G/P lookahead, groups chained by carry; no ripple across bits within a group.
//   Pipeline: stage k computes slice k (bits k*W/S .. (k+1)*W/S-1) from registered carry of stage k-1.
//     Unresolved upper operand bits and Sub travel with the beat; resolved lower Sum bits are carried forward.
//   Latency: exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid, when not stalled.
//   Handshake: adv = !out_valid || out_ready; in_ready = adv; all stage registers (data and valid) update only when adv.
//     Global enable: bubbles are not collapsed; a stalled pipeline holds every stage unchanged.
//     Result beat consumed when out_valid && out_ready; outputs stable while out_valid && !out_ready.
//     Beat offered with in_valid=0 while adv=1 inserts a bubble (valid=0) in stage 0.
//   Throughput: one beat per cycle when out_ready held high.
//   Simultaneous accept/consume in same cycle: legal; pipeline shifts by one.
//   Reset (Rs=0, any time incl. mid-operation): all stage valids 0, all data registers 0, in-flight beats dropped.
//     Output reset values: out_valid=0, Sum=0, cOut=0, Ovf=0, Zero=0; in_ready=1 (combinational from out_valid).
//   Inputs are sampled only on accepted beats; A/B/cIn/Sub may change freely otherwise.
//   Elaboration error if WIDTH % STAGES != 0 or (WIDTH/STAGES) % GROUP != 0.
// TESTING (WIDTH=16, GROUP=4, STAGES=4 unless stated)
//   1 Reset: Rs=0 mid-stream with 3 beats in flight -> out_valid=0, Sum=0, flags 0; no stale beat after Rs=1.
//   2 Add: A=16'hFFFF,B=16'h0001,cIn=0,Sub=0 -> 4 cycles later Sum=16'h0000,cOut=1,Zero=1,Ovf=0.
//   3 Sub overflow: A=16'h8000,B=16'h0001,Sub=1,cIn=0 -> Sum=16'h7FFF,cOut=1,Ovf=1; A=16'h0003,B=16'h0005 -> Sum=16'hFFFE,cOut=0.
//   4 Streaming: 100 back-to-back random beats, out_ready=1 -> one result/cycle, order preserved, matches golden A+Beff+ceff.
//   5 Backpressure: out_ready=0 for 5 cycles with full pipeline -> in_ready=0, Sum/flags held; release -> no loss/duplication.
//   6 Params: WIDTH=32,GROUP=4,STAGES=1 and STAGES=8 -> latency 1 and 8; A=32'h7FFFFFFF+1 -> Sum=32'h80000000,Ovf=1.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each of STAGES pipeline stages resolves one WIDTH/STAGES-bit slice using GROUP-bit lookahead units.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cIn,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             cOut,
    output logic             Ovf,
    output logic             Zero
);

    localparam int SLICE  = WIDTH / STAGES;
    localparam int NGROUP = SLICE / GROUP;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    generate
        if ((WIDTH % STAGES) != 0 || (SLICE % GROUP) != 0) begin : g_bad_params
            $error("pipelined_cla_adder: STAGES must divide WIDTH and GROUP must divide WIDTH/STAGES");
        end
    endgenerate

    // One slice: every bit carry is a flat sum-of-products of the group's G/P terms and the group carry-in.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] s;
        logic             c_grp;
        logic             c_bit;
        logic             term;
        logic             g_grp;
        logic             p_grp;
        g     = a & b;
        p     = a ^ b;
        s     = '0;
        c_grp = cin;
        for (int grp = 0; grp < NGROUP; grp++) begin
            for (int i = 0; i < GROUP; i++) begin
                c_bit = c_grp;
                for (int k = 0; k < i; k++) c_bit &= p[grp*GROUP+k];
                for (int j = 0; j < i; j++) begin
                    term = g[grp*GROUP+j];
                    for (int k = j + 1; k < i; k++) term &= p[grp*GROUP+k];
                    c_bit |= term;
                end
                s[grp*GROUP+i] = p[grp*GROUP+i] ^ c_bit;
            end
            g_grp = 1'b0;
            p_grp = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                term = g[grp*GROUP+j];
                for (int k = j + 1; k < GROUP; k++) term &= p[grp*GROUP+k];
                g_grp |= term;
                p_grp &= p[grp*GROUP+j];
            end
            c_grp = g_grp | (p_grp & c_grp);
        end
        return {c_grp, s};
    endfunction

    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] valid_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_d;
    logic              ovf_d;
    logic              zero_d;

    logic [WIDTH-1:0]  a_in     [STAGES];
    logic [WIDTH-1:0]  b_in     [STAGES];
    logic [WIDTH-1:0]  sum_in   [STAGES];
    logic [STAGES-1:0] carry_in;
    logic [STAGES-1:0] valid_in;
    logic [SLICE:0]    slice_res [STAGES];
    logic              adv;

    // Stage 0 takes the operands with B and the carry pre-conditioned for subtract.
    assign a_in[0]     = A;
    assign b_in[0]     = B ^ {WIDTH{Sub}};
    assign sum_in[0]   = '0;
    assign carry_in[0] = cIn ^ Sub;
    assign valid_in[0] = in_valid;

    generate
        for (genvar k = 1; k < STAGES; k++) begin : g_link
            assign a_in[k]     = a_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign sum_in[k]   = sum_q[k-1];
            assign carry_in[k] = carry_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = cla_slice(a_in[k][k*SLICE +: SLICE], b_in[k][k*SLICE +: SLICE], carry_in[k]);
            a_d[k]       = a_in[k];
            b_d[k]       = b_in[k];
            sum_d[k]     = sum_in[k];
            sum_d[k][k*SLICE +: SLICE] = slice_res[k][SLICE-1:0];
            carry_d[k]   = slice_res[k][SLICE];
            valid_d[k]   = valid_in[k];
        end
        ovf_d  = (a_d[LAST][MSB] == b_d[LAST][MSB]) && (sum_d[LAST][MSB] != a_d[LAST][MSB]);
        zero_d = ~|sum_d[LAST];
    end

    // Single global enable: a stalled output freezes every stage, bubbles included.
    assign adv      = !valid_q[LAST] || out_ready;
    assign in_ready = adv;

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign Sum       = sum_q[LAST];
    assign cOut      = carry_q[LAST];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed and random beats checked against an arithmetic reference queue.
// A 16-bit/4-stage instance carries most traffic; two 32-bit instances cover STAGES=1 and STAGES=8.
module tb_pipelined_cla_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic          Clk = 1'b0;
    logic          Rs  = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          cIn = 1'b0;
    logic          Sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Sum;
    logic          cOut;
    logic          Ovf;
    logic          Zero;

    logic          iv32 = 1'b0;
    logic [31:0]   a32 = '0;
    logic [31:0]   b32 = '0;
    logic          rdy1, ov1, co1, of1, z1;
    logic          rdy8, ov8, co8, of8, z8;
    logic [31:0]   sum1, sum8;

    always #5 Clk = ~Clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(S)) dut (
        .Clk(Clk), .Rs(Rs), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .cIn(cIn), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .cOut(cOut), .Ovf(Ovf), .Zero(Zero)
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(1)) dut_s1 (
        .Clk(Clk), .Rs(Rs), .in_valid(iv32), .in_ready(rdy1), .A(a32), .B(b32),
        .cIn(1'b0), .Sub(1'b0), .out_valid(ov1), .out_ready(1'b1),
        .Sum(sum1), .cOut(co1), .Ovf(of1), .Zero(z1)
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(8)) dut_s8 (
        .Clk(Clk), .Rs(Rs), .in_valid(iv32), .in_ready(rdy8), .A(a32), .B(b32),
        .cIn(1'b0), .Sub(1'b0), .out_valid(ov8), .out_ready(1'b1),
        .Sum(sum8), .cOut(co8), .Ovf(of8), .Zero(z8)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors      = 0;
    int   miscompares    = 0;
    int   cyc            = 0;
    bit   check_latency  = 1'b1;

    // Reference: plain wide arithmetic; overflow judged by whether the true signed sum fits in W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        int           sres;
        be   = sb ? ~b : b;
        ce   = ci ^ sb;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        sres = int'($signed(a)) + int'($signed(be)) + (ce ? 1 : 0);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (sres > 32767) || (sres < -32768);
        e.zero = (full[W-1:0] == '0);
        e.acc  = cyc;
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, score the output beat about to be consumed, record the beat about to be accepted.
    task automatic apply_stimulus(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb, input logic ordy);
        exp_t e;
        in_valid  = iv;
        A         = a;
        B         = b;
        cIn       = ci;
        Sub       = sb;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_beat", {31'b0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("sum",  {16'b0, Sum},  {16'b0, e.sum});
                check_output("cout", {31'b0, cOut}, {31'b0, e.cout});
                check_output("ovf",  {31'b0, Ovf},  {31'b0, e.ovf});
                check_output("zero", {31'b0, Zero}, {31'b0, e.zero});
                if (check_latency) check_output("latency", cyc - e.acc, S);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sb));
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check_output("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic idle_no_stale(input int n);
        for (int i = 0; i < n; i++) begin
            check_output("no_stale", {31'b0, out_valid}, 32'd0);
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_sum",       {16'b0, Sum},       32'd0);
        check_output("rst_cout",      {31'b0, cOut},      32'd0);
        check_output("rst_ovf",       {31'b0, Ovf},       32'd0);
        check_output("rst_zero",      {31'b0, Zero},      32'd0);
        check_output("rst_in_ready",  {31'b0, in_ready},  32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, snap_sum;
        logic         snap_cout, snap_ovf, snap_zero;
        int           n, lat1, lat8;
        logic [31:0]  r_sum1, r_sum8;
        logic         r_co1, r_of1, r_z1, r_co8, r_of8, r_z8;

        $display("[TB] start");
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs();
        Rs = 1'b1;
        @(posedge Clk);
        #1;

        $display("[TB] add wrapping to zero");
        apply_stimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain(20);

        $display("[TB] subtract with overflow and borrow");
        apply_stimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
        drain(20);

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            apply_stimulus(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        in_valid = 1'b0;
        Rs = 1'b0;
        #2;
        check_reset_outputs();
        exp_q.delete();
        @(posedge Clk);
        #1;
        Rs = 1'b1;
        idle_no_stale(8);

        $display("[TB] streaming 100 random beats");
        for (int i = 0; i < 100; i++) begin
            if (i >= S) check_output("stream_tput", {31'b0, out_valid}, 32'd1);
            ra = 16'($urandom);
            rb = 16'($urandom);
            apply_stimulus(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        drain(20);

        $display("[TB] backpressure with full pipeline");
        check_latency = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            apply_stimulus(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
            n++;
        end
        check_output("fill_valid", {31'b0, out_valid}, 32'd1);
        snap_sum  = Sum;
        snap_cout = cOut;
        snap_ovf  = Ovf;
        snap_zero = Zero;
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            apply_stimulus(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b0);
            check_output("stall_in_ready", {31'b0, in_ready},  32'd0);
            check_output("stall_valid",    {31'b0, out_valid}, 32'd1);
            check_output("stall_sum",      {16'b0, Sum},       {16'b0, snap_sum});
            check_output("stall_flags",    {29'b0, cOut, Ovf, Zero}, {29'b0, snap_cout, snap_ovf, snap_zero});
        end
        drain(20);
        idle_no_stale(3);
        check_latency = 1'b1;

        $display("[TB] 32-bit instances with STAGES=1 and STAGES=8");
        iv32 = 1'b1;
        a32  = 32'h7FFF_FFFF;
        b32  = 32'h0000_0001;
        lat1 = 0;
        lat8 = 0;
        r_sum1 = '0; r_co1 = 1'b0; r_of1 = 1'b0; r_z1 = 1'b0;
        r_sum8 = '0; r_co8 = 1'b0; r_of8 = 1'b0; r_z8 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk);
            #1;
            iv32 = 1'b0;
            if (ov1 && lat1 == 0) begin
                lat1 = i; r_sum1 = sum1; r_co1 = co1; r_of1 = of1; r_z1 = z1;
            end
            if (ov8 && lat8 == 0) begin
                lat8 = i; r_sum8 = sum8; r_co8 = co8; r_of8 = of8; r_z8 = z8;
            end
        end
        check_output("s1_latency", lat1, 32'd1);
        check_output("s1_sum",     r_sum1, 32'h8000_0000);
        check_output("s1_flags",   {29'b0, r_co1, r_of1, r_z1}, 32'b010);
        check_output("s8_latency", lat8, 32'd8);
        check_output("s8_sum",     r_sum8, 32'h8000_0000);
        check_output("s8_flags",   {29'b0, r_co8, r_of8, r_z8}, 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

endmodule
